// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx between N_REQ byte-stream
// requesters. A grant is held for a whole packet (req_last_i) or up to MAX_BURST bytes.
// An optional {4'hA, id} header byte precedes each granted burst.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter bit          HEADER_EN    = 1'b1,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned IDLE_TIMEOUT = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [7:0]         utx_data_o,
    output logic               utx_ready_o,
    input  logic               utx_valid_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o
);

    localparam int unsigned PtrW   = $clog2(N_REQ);
    localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
    // A disabled timeout still needs a legal one-bit counter.
    localparam int unsigned ToW    = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StBody
    } state_e;

    state_e              state_q;
    logic [PtrW-1:0]     ptr_q;
    logic [PtrW-1:0]     gidx_q;
    logic [N_REQ-1:0]    grant_q;
    logic [BurstW-1:0]   burst_cnt_q;
    logic [ToW-1:0]      to_cnt_q;

    logic                pick_found;
    logic [PtrW-1:0]     pick_idx;
    logic [N_REQ-1:0]    pick_onehot;
    logic [PtrW-1:0]     cand;
    logic [7:0]          sel_data;
    logic                sel_valid;
    logic                sel_last;
    logic                xfer;

    assign sel_data  = req_data_i[{gidx_q, 3'b000} +: 8];
    assign sel_valid = req_valid_i[gidx_q];
    assign sel_last  = req_last_i[gidx_q];
    assign xfer      = utx_ready_o && utx_valid_i;

    assign grant_o = grant_q;
    assign busy_o  = (state_q != StIdle);

    // Round-robin pick: first valid requester at or after ptr+1, modulo N_REQ.
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = PtrW'((32'(ptr_q) + i) % N_REQ);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_onehot[pick_idx] = 1'b1;
    end

    // Output mux: header, granted requester passthrough, or quiet.
    always_comb begin
        utx_data_o  = 8'h00;
        utx_ready_o = 1'b0;
        req_ready_o = '0;
        unique case (state_q)
            StHdr: begin
                utx_data_o  = {4'hA, 4'(gidx_q)};
                utx_ready_o = 1'b1;
            end
            StBody: begin
                utx_data_o          = sel_data;
                utx_ready_o         = sel_valid;
                req_ready_o[gidx_q] = utx_valid_i;
            end
            default: ;
        endcase
    end

    // Arbiter state machine, grant, pointer and burst/timeout counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            ptr_q       <= PtrW'(N_REQ - 1);
            gidx_q      <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        gidx_q      <= pick_idx;
                        grant_q     <= pick_onehot;
                        burst_cnt_q <= '0;
                        to_cnt_q    <= '0;
                        state_q     <= HEADER_EN ? StHdr : StBody;
                    end
                end
                StHdr: begin
                    if (xfer) begin
                        state_q <= StBody;
                    end
                end
                StBody: begin
                    if (sel_valid) begin
                        to_cnt_q <= '0;
                        if (xfer) begin
                            burst_cnt_q <= burst_cnt_q + 1'b1;
                            if (sel_last || burst_cnt_q == BurstW'(MAX_BURST - 1)) begin
                                state_q <= StIdle;
                                ptr_q   <= gidx_q;
                                grant_q <= '0;
                            end
                        end
                    end else if (IDLE_TIMEOUT != 0 && to_cnt_q == ToW'(IDLE_TIMEOUT - 1)) begin
                        // Requester went quiet too long: revoke without consuming a byte.
                        state_q <= StIdle;
                        ptr_q   <= gidx_q;
                        grant_q <= '0;
                    end else if (to_cnt_q != '1) begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues and a uart_tx-like sink around the DUT,
// with per-cycle traces checked by one task per scenario.
module tb_uart_tx_arbiter;

    localparam int TR = 1024;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  utx_data;
    logic        utx_ready;
    logic        utx_valid;
    logic [3:0]  grant;
    logic        busy;

    uart_tx_arbiter #(
        .N_REQ       (4),
        .HEADER_EN   (1'b1),
        .MAX_BURST   (3),
        .IDLE_TIMEOUT(4)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_last_i (req_last),
        .req_ready_o(req_ready),
        .utx_data_o (utx_data),
        .utx_ready_o(utx_ready),
        .utx_valid_i(utx_valid),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Requester queues: {last, data}
    logic [8:0] rmem [4][16];
    int         rhead [4];
    int         rlen [4];
    bit         stall;
    int         gap_left;
    int         cyc;

    // Per-cycle traces sampled at the falling edge
    logic       bsy_tr [TR];
    logic [3:0] gnt_tr [TR];
    logic [3:0] rr_tr [TR];
    logic [7:0] dat_tr [TR];
    logic       rdy_tr [TR];

    // UART transfer log
    logic [7:0] xdat [64];
    logic [3:0] xgnt [64];
    int         xcyc [64];
    int         xcnt;

    int checks;
    int failures;

    task automatic push(input int k, input logic [7:0] d, input logic l);
        rmem[k][rlen[k]] = {l, d};
        rlen[k]++;
    endtask

    task automatic drive();
        for (int k = 0; k < 4; k++) begin
            if (rhead[k] < rlen[k]) begin
                req_valid[k]        = 1'b1;
                req_data[8*k +: 8]  = rmem[k][rhead[k]][7:0];
                req_last[k]         = rmem[k][rhead[k]][8];
            end else begin
                req_valid[k]        = 1'b0;
                req_data[8*k +: 8]  = 8'h00;
                req_last[k]         = 1'b0;
            end
        end
        utx_valid = !stall && (gap_left == 0);
    endtask

    // One clock: observe at negedge, update environment just after posedge.
    task automatic cycle();
        bit       xfer;
        bit [3:0] pop;
        @(negedge clk);
        if (cyc < TR) begin
            bsy_tr[cyc] = busy;
            gnt_tr[cyc] = grant;
            rr_tr[cyc]  = req_ready;
            dat_tr[cyc] = utx_data;
            rdy_tr[cyc] = utx_ready;
        end
        xfer = !reset_i && utx_ready && utx_valid;
        if (xfer && xcnt < 64) begin
            xdat[xcnt] = utx_data;
            xgnt[xcnt] = grant;
            xcyc[xcnt] = cyc;
            xcnt++;
        end
        for (int k = 0; k < 4; k++) pop[k] = !reset_i && req_valid[k] && req_ready[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) if (pop[k]) rhead[k]++;
        if (xfer) gap_left = 2;
        else if (gap_left > 0) gap_left--;
        cyc++;
        drive();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rhead[k] = 0;
            rlen[k]  = 0;
        end
        xcnt     = 0;
        stall    = 1'b0;
        gap_left = 0;
        drive();
        cycle();
        cycle();
        reset_i = 1'b0;
        drive();
    endtask

    task automatic test_reset();
        int c;
        reset_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rhead[k] = 0;
            rlen[k]  = 0;
            push(k, 8'h11, 1'b1);
        end
        xcnt = 0;
        stall = 1'b0;
        gap_left = 0;
        drive();
        cycle();
        cycle();
        c = cyc - 1;
        checks++;
        if (bsy_tr[c] !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b want 0", bsy_tr[c]);
        end
        checks++;
        if (gnt_tr[c] !== 4'b0000) begin
            failures++; $display("FAIL reset_grant: got %b want 0000", gnt_tr[c]);
        end
        checks++;
        if (rr_tr[c] !== 4'b0000) begin
            failures++; $display("FAIL reset_req_ready: got %b want 0000", rr_tr[c]);
        end
        checks++;
        if (rdy_tr[c] !== 1'b0) begin
            failures++; $display("FAIL reset_utx_ready: got %b want 0", rdy_tr[c]);
        end
        checks++;
        if (dat_tr[c] !== 8'h00) begin
            failures++; $display("FAIL reset_utx_data: got %h want 00", dat_tr[c]);
        end
        reset_i = 1'b0;
        drive();
        c = cyc;
        cycle();
        cycle();
        checks++;
        if (bsy_tr[c] !== 1'b0 || bsy_tr[c+1] !== 1'b1) begin
            failures++;
            $display("FAIL grant_latency: got busy %b,%b want 0,1", bsy_tr[c], bsy_tr[c+1]);
        end
        checks++;
        if (gnt_tr[c+1] !== 4'b0001 || dat_tr[c+1] !== 8'hA0) begin
            failures++;
            $display("FAIL first_grant: got %b/%h want 0001/a0", gnt_tr[c+1], dat_tr[c+1]);
        end
    endtask

    task automatic test_single();
        int c0;
        logic [7:0] exp_d [3];
        exp_d = '{8'hA1, 8'h55, 8'h3C};
        do_reset();
        c0 = cyc;
        push(1, 8'h55, 1'b0);
        push(1, 8'h3C, 1'b1);
        drive();
        repeat (14) cycle();
        checks++;
        if (xcnt !== 3) begin
            failures++; $display("FAIL single_count: got %0d want 3", xcnt);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (xdat[i] !== exp_d[i] || xgnt[i] !== 4'b0010) begin
                failures++;
                $display("FAIL single_xfer%0d: got %h/%b want %h/0010", i, xdat[i], xgnt[i],
                         exp_d[i]);
            end
        end
        checks++;
        if (bsy_tr[c0] !== 1'b0 || bsy_tr[c0+1] !== 1'b1) begin
            failures++;
            $display("FAIL single_latency: got %b,%b want 0,1", bsy_tr[c0], bsy_tr[c0+1]);
        end
        checks++;
        if (bsy_tr[cyc-1] !== 1'b0 || gnt_tr[cyc-1] !== 4'b0000) begin
            failures++;
            $display("FAIL single_release: got %b/%b want 0/0000", bsy_tr[cyc-1],
                     gnt_tr[cyc-1]);
        end
    endtask

    task automatic test_round_robin();
        int c0;
        int t;
        int bad;
        logic [7:0] exp_d [10];
        exp_d = '{8'hA0, 8'hC0, 8'hA1, 8'hD0, 8'hA2, 8'hE0, 8'hA3, 8'hF0, 8'hA0, 8'hC1};
        do_reset();
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            push(k, 8'hC0 | 8'(k << 4), 1'b1);
            push(k, 8'hC1 | 8'(k << 4), 1'b1);
        end
        drive();
        repeat (40) cycle();
        checks++;
        if (xcnt < 10) begin
            failures++; $display("FAIL rr_count: got %0d want >=10", xcnt);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (xdat[i] !== exp_d[i]) begin
                failures++; $display("FAIL rr_xfer%0d: got %h want %h", i, xdat[i], exp_d[i]);
            end
        end
        for (int p = 0; p < 4; p++) begin
            t = xcyc[2*p+1];
            checks++;
            if (bsy_tr[t+1] !== 1'b0 || bsy_tr[t+2] !== 1'b1) begin
                failures++;
                $display("FAIL rr_gap%0d: got busy %b,%b want 0,1", p, bsy_tr[t+1],
                         bsy_tr[t+2]);
            end
        end
        bad = 0;
        for (int i = c0; i < cyc; i++) if ((rr_tr[i] & ~gnt_tr[i]) != 4'b0000) bad++;
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL rr_nongranted_ack: got %0d cycles want 0", bad);
        end
    endtask

    task automatic test_burst_cap();
        logic [7:0] exp_d [9];
        exp_d = '{8'hA2, 8'h20, 8'h21, 8'h22, 8'hA3, 8'h30, 8'hA2, 8'h23, 8'h24};
        do_reset();
        push(2, 8'h20, 1'b0);
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h23, 1'b0);
        push(2, 8'h24, 1'b1);
        push(3, 8'h30, 1'b1);
        drive();
        repeat (50) cycle();
        checks++;
        if (xcnt !== 9) begin
            failures++; $display("FAIL burst_count: got %0d want 9", xcnt);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (xdat[i] !== exp_d[i]) begin
                failures++; $display("FAIL burst_xfer%0d: got %h want %h", i, xdat[i], exp_d[i]);
            end
        end
        checks++;
        if (xgnt[3] !== 4'b0100 || xgnt[4] !== 4'b1000) begin
            failures++;
            $display("FAIL burst_grants: got %b,%b want 0100,1000", xgnt[3], xgnt[4]);
        end
    endtask

    task automatic test_timeout();
        int t;
        logic [7:0] exp_d [4];
        exp_d = '{8'hA0, 8'h40, 8'hA1, 8'h41};
        do_reset();
        push(0, 8'h40, 1'b0);
        push(1, 8'h41, 1'b1);
        drive();
        repeat (25) cycle();
        checks++;
        if (xcnt !== 4) begin
            failures++; $display("FAIL timeout_count: got %0d want 4", xcnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (xdat[i] !== exp_d[i]) begin
                failures++;
                $display("FAIL timeout_xfer%0d: got %h want %h", i, xdat[i], exp_d[i]);
            end
        end
        t = xcyc[1];
        checks++;
        if (bsy_tr[t+4] !== 1'b1 || bsy_tr[t+5] !== 1'b0) begin
            failures++;
            $display("FAIL timeout_release: got busy %b,%b want 1,0", bsy_tr[t+4], bsy_tr[t+5]);
        end
        checks++;
        if (gnt_tr[t+6] !== 4'b0010) begin
            failures++; $display("FAIL timeout_next_grant: got %b want 0010", gnt_tr[t+6]);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        int r;
        do_reset();
        c0 = cyc;
        push(2, 8'h20, 1'b0);
        push(2, 8'h21, 1'b0);
        push(2, 8'h22, 1'b1);
        drive();
        repeat (6) cycle();
        checks++;
        if (bsy_tr[c0+5] !== 1'b1 || xcnt !== 2) begin
            failures++;
            $display("FAIL midrst_pre: got busy %b xfers %0d want 1,2", bsy_tr[c0+5], xcnt);
        end
        reset_i = 1'b1;
        push(0, 8'h50, 1'b1);
        drive();
        cycle();
        reset_i = 1'b0;
        drive();
        r = cyc;
        repeat (10) cycle();
        checks++;
        if (bsy_tr[r] !== 1'b0 || gnt_tr[r] !== 4'b0000 || rr_tr[r] !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_state: got busy %b grant %b rr %b want 0,0000,0000",
                     bsy_tr[r], gnt_tr[r], rr_tr[r]);
        end
        checks++;
        if (rdy_tr[r] !== 1'b0 || dat_tr[r] !== 8'h00) begin
            failures++;
            $display("FAIL midrst_utx: got ready %b data %h want 0,00", rdy_tr[r], dat_tr[r]);
        end
        checks++;
        if (gnt_tr[r+1] !== 4'b0001) begin
            failures++; $display("FAIL midrst_first_grant: got %b want 0001", gnt_tr[r+1]);
        end
        checks++;
        if (xdat[2] !== 8'hA0 || xdat[3] !== 8'h50) begin
            failures++;
            $display("FAIL midrst_xfers: got %h,%h want a0,50", xdat[2], xdat[3]);
        end
    endtask

    task automatic test_backpressure();
        int s0;
        int bad;
        do_reset();
        push(3, 8'h70, 1'b0);
        push(3, 8'h71, 1'b1);
        drive();
        cycle();
        cycle();
        stall = 1'b1;
        drive();
        s0 = cyc;
        repeat (20) cycle();
        bad = 0;
        for (int i = s0; i < s0 + 20; i++) begin
            if (rr_tr[i] !== 4'b0000 || dat_tr[i] !== 8'h70 || rdy_tr[i] !== 1'b1 ||
                gnt_tr[i] !== 4'b1000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (xcnt !== 1) begin
            failures++; $display("FAIL bp_stalled_count: got %0d want 1", xcnt);
        end
        stall = 1'b0;
        drive();
        repeat (15) cycle();
        checks++;
        if (xcnt !== 3 || xdat[1] !== 8'h70 || xdat[2] !== 8'h71) begin
            failures++;
            $display("FAIL bp_drain: got %0d xfers %h,%h want 3 xfers 70,71", xcnt, xdat[1],
                     xdat[2]);
        end
        checks++;
        if (bsy_tr[cyc-1] !== 1'b0) begin
            failures++; $display("FAIL bp_release: got busy %b want 0", bsy_tr[cyc-1]);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        xcnt      = 0;
        stall     = 1'b0;
        gap_left  = 0;
        reset_i   = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        utx_valid = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_timeout();
        test_reset_mid();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
